shift_left_iterative: RTL and testbench
=======================================

# shift_left_iterative

Multi-cycle logical left shifter with valid/ready handshakes on both sides. It shifts a 32-bit operand left by one bit per clock and zero-fills the LSBs. It is the left-direction companion to the combinational right shifters in the ALU shifter set. It serves the multi-cycle datapath, where area matters more than latency.

## Interface
- N, 32: operand width. Treated as a constant; only N=32 is required.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- i_valid  input  1  upstream presents a new operand/shamt pair
- o_ready  output  1  block can accept a new pair (high only in IDLE)
- in  input  N  operand to shift
- shamt  input  $clog2(N)  shift amount, 0..N-1
- o_valid  output  1  result on `out` is valid (high only in DONE)
- i_ready  input  1  downstream accepts the result
- out  output  N  result, in << shamt, zero-filled

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- The block holds a result register `acc` [N-1:0] and a down-counter `cnt` [$clog2(N)-1:0].
- `out` is driven directly from `acc` in all states.
- **Input handshake:** occurs on an edge where i_valid && o_ready.
  - `acc` <= in and `cnt` <= shamt.
  - Next state is DONE if shamt==0; otherwise SHIFT.
- **SHIFT:** on every edge, `acc` <= {acc[N-2:0],1'b0} and `cnt` <= cnt-1.
  - When cnt==1 on that edge, next state is DONE.
- **DONE:** o_valid=1. `acc` holds its value.
  - On an edge with i_ready=1, next state is IDLE.
  - While i_ready=0, the block stays in DONE indefinitely and `out` stays stable.
- **IDLE:** o_ready=1 and o_valid=0. `acc` holds the last result, so `out` is not cleared.
- In SHIFT and DONE:
  - i_valid is ignored.
  - `in` and `shamt` may change freely; they are sampled only at the input handshake.
- Bits shifted out of the MSB are discarded. There is no overflow flag.
- Arithmetic: `cnt` is an unsigned $clog2(N)-bit value. The decrement never wraps, because SHIFT is entered only with cnt>=1 and is left at cnt==1.

## Timing
- **Reset values:** state=IDLE, acc=0, cnt=0, so out=0, o_valid=0, o_ready=1.
- **Latency:** o_valid rises after shamt+1 rising edges, counting the handshake edge as edge 1.
  - shamt=0 gives DONE in the cycle immediately after the handshake.
  - shamt=31 gives 32 edges.
- **Throughput:** at most one operation per shamt+2 cycles.
  - The DONE->IDLE edge is mandatory.
  - There is no accept in the same cycle as a result handoff.
- o_ready and o_valid are Moore outputs, decoded from state only. There is no combinational path from any input to any output.
- **Reset mid-operation:** rst has priority over all transitions.
  - An in-flight SHIFT or DONE is discarded.
  - The next cycle is IDLE with out=0.
- **Simultaneous events:**
  - i_valid=1 during SHIFT or DONE is not accepted. Upstream must hold it until o_ready.
  - i_ready=1 outside DONE has no effect.

## Structure
- Shared package `shifter_pkg` holds:
  - localparam N_SHIFT=32 and SHAMT_W=$clog2(N_SHIFT), reused by all shifters.
  - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t.
- Single flat module. No sub-module is needed; the counter and 1-bit shift are inline always_ff logic.

## Test plan
- **Reset:** hold rst 2 cycles. Then out=0, o_valid=0, o_ready=1.
- **Basic shift:** in=32'h0000_0001, shamt=4, i_ready=1. o_valid is seen 5 edges after the handshake with out=32'h0000_0010. o_ready returns 1 the following cycle.
- **Zero and max shift:**
  - in=32'hDEAD_BEEF, shamt=0 gives out=32'hDEAD_BEEF in the next cycle.
  - in=32'hFFFF_FFFF, shamt=31 gives out=32'h8000_0000 after 32 edges.
- **Backpressure:** in=32'h0000_00F0, shamt=8, i_ready=0 for 10 cycles after o_valid. out stays 32'h0000_F000 and o_valid stays 1. Meanwhile i_valid=1 with new data is ignored (o_ready=0).
- **Input change during SHIFT:** change in/shamt every cycle after the handshake. The result still matches the sampled pair.
- **Reset mid-operation:** assert rst in the 3rd SHIFT cycle. The next cycle is IDLE with out=0. A fresh in=32'h1, shamt=1 then yields 32'h2 after 2 edges.

Source files
------------

// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
//
// Shared definitions for the ALU shifter set.
//   N_SHIFT        : default operand width for every shifter
//   SHAMT_W        : width of a shift-amount field for N_SHIFT
//   shift_state_t  : state encoding for the iterative (multi-cycle) shifters
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int N_SHIFT = 32;
    localparam int SHAMT_W = $clog2(N_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

endpackage : shifter_pkg

// File: rtl/shift_left_iterative.sv
// ---------------------------------------------------------------------------
// shift_left_iterative
//
// Multi-cycle logical left shifter. An accepted operand is shifted left by one
// bit per clock, zero-filling the LSBs, until shamt bits have been applied.
// Bits leaving the MSB are dropped.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   i_valid  : upstream presents an operand / shift-amount pair
//   o_ready  : block can accept a pair (IDLE only)
//   in       : operand
//   shamt    : shift amount, 0..N-1
//   o_valid  : result on out is valid (DONE only)
//   i_ready  : downstream takes the result
//   out      : in << shamt, driven straight from the accumulator
// ---------------------------------------------------------------------------
module shift_left_iterative
    import shifter_pkg::*;
#(
    parameter int N = N_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [N-1:0]         out
);

    localparam int SW = $clog2(N);

    shift_state_t  state;
    logic [N-1:0]  acc;
    logic [SW-1:0] cnt;
    logic          o_ready_r;
    logic          o_valid_r;

    // Handshake flags are registered alongside the state so both outputs are
    // pure flop outputs with no path from any input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            o_ready_r <= 1'b1;
            o_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        acc <= in;
                        cnt <= shamt;
                        if (shamt == '0) begin
                            state     <= S_DONE;
                            o_ready_r <= 1'b0;
                            o_valid_r <= 1'b1;
                        end else begin
                            state     <= S_SHIFT;
                            o_ready_r <= 1'b0;
                            o_valid_r <= 1'b0;
                        end
                    end
                end

                S_SHIFT: begin
                    acc <= {acc[N-2:0], 1'b0};
                    // SHIFT is only entered with cnt >= 1 and left at cnt == 1,
                    // so this decrement cannot wrap.
                    cnt <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        state     <= S_DONE;
                        o_valid_r <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (i_ready) begin
                        state     <= S_IDLE;
                        o_valid_r <= 1'b0;
                        o_ready_r <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    o_ready_r <= 1'b1;
                    o_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = o_ready_r;
    assign o_valid = o_valid_r;
    assign out     = acc;

endmodule : shift_left_iterative

// File: tb/tb_shift_left_iterative.sv
// ---------------------------------------------------------------------------
// tb_shift_left_iterative
//
// Directed bench for shift_left_iterative. Inputs are driven and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_left_iterative;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] in_d;
    logic [4:0]  shamt_d;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] out_d;

    int n_checks;
    int n_pass;

    shift_left_iterative #(.N(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .in      (in_d),
        .shamt   (shamt_d),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .out     (out_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for o_valid. Edge count starts
    // at 1 on the handshake edge. If scramble is set, in/shamt change every
    // cycle after the handshake.
    task automatic start_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                            input logic [31:0] exp_out, input int exp_edges,
                            input bit scramble);
        int edges;
        @(negedge clk);
        check({tag, ".ready_before"}, {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1;
        in_d    = a;
        shamt_d = s;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        i_valid = 1'b0;
        while (!o_valid && edges < 40) begin
            if (scramble) begin
                in_d    = $urandom;
                shamt_d = 5'($urandom);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(edges), 32'(exp_edges));
        check({tag, ".out"}, out_d, exp_out);
        check({tag, ".ready_in_done"}, {31'd0, o_ready}, 32'd0);
    endtask

    // With i_ready high, DONE must hand back to IDLE on the next edge.
    task automatic finish_op(input string tag, input logic [31:0] exp_out);
        i_ready = 1'b1;
        @(negedge clk);
        check({tag, ".ready_after"}, {31'd0, o_ready}, 32'd1);
        check({tag, ".valid_after"}, {31'd0, o_valid}, 32'd0);
        check({tag, ".out_held"}, out_d, exp_out);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        in_d     = 32'h0;
        shamt_d  = 5'd0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.out", out_d, 32'h0);
        check("reset.valid", {31'd0, o_valid}, 32'd0);
        check("reset.ready", {31'd0, o_ready}, 32'd1);

        // Basic shift
        start_op("basic", 32'h0000_0001, 5'd4, 32'h0000_0010, 5, 1'b0);
        finish_op("basic", 32'h0000_0010);

        // Zero shift
        start_op("zero", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b0);
        finish_op("zero", 32'hDEAD_BEEF);

        // Max shift
        start_op("max", 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 32, 1'b0);
        finish_op("max", 32'h8000_0000);

        // Backpressure with an ignored new request
        i_ready = 1'b0;
        start_op("bp", 32'h0000_00F0, 5'd8, 32'h0000_F000, 9, 1'b0);
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            in_d    = 32'h1234_5678;
            shamt_d = 5'd3;
            @(negedge clk);
            check("bp.hold_out", out_d, 32'h0000_F000);
            check("bp.hold_valid", {31'd0, o_valid}, 32'd1);
            check("bp.hold_ready", {31'd0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        finish_op("bp", 32'h0000_F000);

        // Inputs change every cycle after the handshake
        start_op("scramble", 32'h8000_0003, 5'd3, 32'h0000_0018, 4, 1'b1);
        finish_op("scramble", 32'h0000_0018);
        start_op("scramble2", 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000, 17, 1'b1);
        finish_op("scramble2", 32'hA5A5_0000);

        // Reset in the third SHIFT cycle
        @(negedge clk);
        i_valid = 1'b1;
        in_d    = 32'h0000_0005;
        shamt_d = 5'd10;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst.busy", {31'd0, o_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.out", out_d, 32'h0);
        check("midrst.ready", {31'd0, o_ready}, 32'd1);
        check("midrst.valid", {31'd0, o_valid}, 32'd0);
        start_op("post_rst", 32'h0000_0001, 5'd1, 32'h0000_0002, 2, 1'b0);
        finish_op("post_rst", 32'h0000_0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on run time in case a wait goes astray.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_left_iterative
